ex_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU and its ALU control decoder.
- Decodes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO from the R-type ALUOp and funct fields.
- Runs iterative shift-add multiply and restoring divide, and owns the architectural HI/LO registers.
- Drives a busy signal that the hazard unit uses to stall IF/ID/EX.

---
 rtl/ex_muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit that owns the HI/LO registers and raises busy while working.
// Define MULDIV_FAST_MUL_EN to swap the shift-add multiplier for a single-cycle combinational one.
module ex_muldiv_unit #(
   parameter int NB_DATA   = 32,
   parameter int NB_FUNCT  = 6,
   parameter int NB_ALU_OP = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic                 i_flush,
   input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
   input  logic [NB_FUNCT-1:0]  i_funct,
   input  logic [NB_DATA-1:0]   i_rs_data,
   input  logic [NB_DATA-1:0]   i_rt_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [NB_DATA-1:0]   o_result,
   output logic [NB_DATA-1:0]   o_hi,
   output logic [NB_DATA-1:0]   o_lo
);

   localparam int CW = $clog2(NB_DATA) + 1;
   localparam logic [CW-1:0]        CNT_LAST = CW'(NB_DATA - 1);
   localparam logic [NB_ALU_OP-1:0] ALU_OP_R = NB_ALU_OP'(4'b0010);
   localparam logic [NB_FUNCT-1:0]  F_MFHI   = NB_FUNCT'(6'b010000);
   localparam logic [NB_FUNCT-1:0]  F_MTHI   = NB_FUNCT'(6'b010001);
   localparam logic [NB_FUNCT-1:0]  F_MFLO   = NB_FUNCT'(6'b010010);
   localparam logic [NB_FUNCT-1:0]  F_MTLO   = NB_FUNCT'(6'b010011);
   localparam logic [NB_FUNCT-1:0]  F_MULT   = NB_FUNCT'(6'b011000);
   localparam logic [NB_FUNCT-1:0]  F_MULTU  = NB_FUNCT'(6'b011001);
   localparam logic [NB_FUNCT-1:0]  F_DIV    = NB_FUNCT'(6'b011010);
   localparam logic [NB_FUNCT-1:0]  F_DIVU   = NB_FUNCT'(6'b011011);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [2*NB_DATA-1:0]   acc_q, acc_d;
   logic [NB_DATA-1:0]     op_b_q;
   logic [NB_DATA-1:0]     dividend_q;
   logic                   is_div_q;
   logic                   neg_res_q;
   logic                   neg_rem_q;
   logic                   div_zero_q;
   logic [NB_DATA-1:0]     hi_q, lo_q;
   logic                   busy_q, done_q;

   logic                   hit, start_mul, start_div, start_any;
   logic                   wr_hi, wr_lo, op_signed;
   logic                   rs_neg, rt_neg;
   logic [NB_DATA-1:0]     rs_abs, rt_abs;
   logic [NB_DATA:0]       mul_sum, div_upper, div_trial;
   logic [2*NB_DATA-1:0]   mul_step, div_step, prod_fix;
   logic [NB_DATA-1:0]     quo_raw, rem_raw;
   logic [NB_DATA-1:0]     res_hi, res_lo;

   always_comb begin
      hit       = i_valid && (i_alu_op_CU == ALU_OP_R);
      start_mul = hit && ((i_funct == F_MULT) || (i_funct == F_MULTU));
      start_div = hit && ((i_funct == F_DIV)  || (i_funct == F_DIVU));
      start_any = start_mul || start_div;
      wr_hi     = hit && (i_funct == F_MTHI);
      wr_lo     = hit && (i_funct == F_MTLO);
      op_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
      rs_neg    = op_signed && i_rs_data[NB_DATA-1];
      rt_neg    = op_signed && i_rt_data[NB_DATA-1];
      rs_abs    = rs_neg ? -i_rs_data : i_rs_data;
      rt_abs    = rt_neg ? -i_rt_data : i_rt_data;
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, op_b_q} : '0);
      mul_step = {mul_sum, acc_q[NB_DATA-1:1]};
   end

   // Restoring divide: acc = {remainder, dividend/quotient}, shifted left each step.
   always_comb begin
      div_upper = acc_q[2*NB_DATA-1:NB_DATA-1];
      div_trial = div_upper - {1'b0, op_b_q};
      if (div_trial[NB_DATA])
         div_step = {div_upper[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
      else
         div_step = {div_trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
   end

   always_comb begin
      acc_d = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start_div)
               acc_d = {{NB_DATA{1'b0}}, rs_abs};
            else if (start_mul)
`ifdef MULDIV_FAST_MUL_EN
               acc_d = {{NB_DATA{1'b0}}, rs_abs} * {{NB_DATA{1'b0}}, rt_abs};
`else
               acc_d = {{NB_DATA{1'b0}}, rt_abs};
`endif
         end
         S_MUL:   acc_d = mul_step;
         S_DIV:   acc_d = div_step;
         default: acc_d = acc_q;
      endcase
   end

   // Sign correction of the unsigned magnitude result, applied while in DONE.
   always_comb begin
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_raw  = acc_q[NB_DATA-1:0];
      rem_raw  = acc_q[2*NB_DATA-1:NB_DATA];
      if (!is_div_q) begin
         res_hi = prod_fix[2*NB_DATA-1:NB_DATA];
         res_lo = prod_fix[NB_DATA-1:0];
      end else if (div_zero_q) begin
         res_hi = dividend_q;
         res_lo = '1;
      end else begin
         res_hi = neg_rem_q ? -rem_raw : rem_raw;
         res_lo = neg_res_q ? -quo_raw : quo_raw;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         op_b_q     <= '0;
         dividend_q <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (i_flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  done_q <= 1'b0;
                  cnt_q  <= '0;
                  if (start_any) begin
                     op_b_q     <= start_div ? rt_abs : rs_abs;
                     dividend_q <= i_rs_data;
                     is_div_q   <= start_div;
                     neg_res_q  <= rs_neg ^ rt_neg;
                     neg_rem_q  <= rs_neg;
                     div_zero_q <= (i_rt_data == '0);
                     busy_q     <= 1'b1;
                     if (start_div) begin
                        state_q <= S_DIV;
                     end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
`else
                        state_q <= S_MUL;
`endif
                     end
                  end else begin
                     if (wr_hi) hi_q <= i_rs_data;
                     if (wr_lo) lo_q <= i_rs_data;
                  end
               end
               S_MUL, S_DIV: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
               S_DONE: begin
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      o_result = '0;
      if (hit && (i_funct == F_MFHI)) o_result = hi_q;
      if (hit && (i_funct == F_MFLO)) o_result = lo_q;
   end

   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_hi   = hi_q;
   assign o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: multiply/divide results, HI/LO moves, flush and reset behaviour.
module tb_ex_muldiv_unit;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        i_flush;
   logic [3:0]  i_alu_op_CU;
   logic [5:0]  i_funct;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int n_cyc;
   int n_busy;
   logic seen_done;

   ex_muldiv_unit #(.NB_DATA(32), .NB_FUNCT(6), .NB_ALU_OP(4)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .i_flush     (i_flush),
      .i_alu_op_CU (i_alu_op_CU),
      .i_funct     (i_funct),
      .i_rs_data   (i_rs_data),
      .i_rt_data   (i_rt_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result),
      .o_hi        (o_hi),
      .o_lo        (o_lo)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
         $display("check %-16s obs=%08h exp=%08h", tag, obs, exp);
      end else begin
         $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   // Presents one instruction for a single accept edge, returning #1 after it.
   task automatic issue(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt,
                        input logic fl);
      i_valid     = 1'b1;
      i_alu_op_CU = 4'b0010;
      i_funct     = funct;
      i_rs_data   = rs;
      i_rt_data   = rt;
      i_flush     = fl;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      i_funct = 6'b000000;
   endtask

   // Counts cycles (sampled at negedge) until o_done, then steps past the HI/LO write edge.
   task automatic wait_done(output int cyc, output int busy);
      cyc  = 0;
      busy = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge i_clk);
         cyc++;
         if (o_busy) busy++;
         if (o_done) break;
      end
      if (!o_done) cyc = 999;
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [5:0] funct, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(funct, rs, rt, 1'b0);
      wait_done(n_cyc, n_busy);
      check({tag, "_lat"}, 32'(n_cyc), 32'd33);
      check({tag, "_hi"}, o_hi, exp_hi);
      check({tag, "_lo"}, o_lo, exp_lo);
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_valid     = 1'b0;
      i_flush     = 1'b0;
      i_alu_op_CU = 4'b0000;
      i_funct     = 6'b000000;
      i_rs_data   = '0;
      i_rt_data   = '0;
      #12;
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_hi", o_hi, 32'h0);
      check("rst_lo", o_lo, 32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      issue(F_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      wait_done(n_cyc, n_busy);
      check("multu_lat", 32'(n_cyc), 32'd33);
      check("multu_busycyc", 32'(n_busy), 32'd33);
      check("multu_hi", o_hi, 32'h00000001);
      check("multu_lo", o_lo, 32'hFFFFFFFE);
      check("multu_busy_off", {31'd0, o_busy}, 32'd0);

      run_op("mult", F_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("divu_zero", F_DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
      run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      issue(F_MTHI, 32'hAAAA5555, 32'h0, 1'b0);
      issue(F_MTLO, 32'h13579BDF, 32'h0, 1'b0);
      i_valid = 1'b1;
      i_funct = F_MFHI;
      #1;
      check("mfhi", o_result, 32'hAAAA5555);
      i_funct = F_MFLO;
      #1;
      check("mflo", o_result, 32'h13579BDF);
      i_alu_op_CU = 4'b0000;
      #1;
      check("mflo_not_rtype", o_result, 32'h0);
      i_alu_op_CU = 4'b0010;
      i_funct     = 6'b100000;
      #1;
      check("other_funct", o_result, 32'h0);
      i_valid = 1'b0;
      @(posedge i_clk);
      #1;

      // MTLO arriving while busy must be dropped.
      issue(F_MULTU, 32'd3, 32'd5, 1'b0);
      issue(F_MTLO, 32'hDEADBEEF, 32'h0, 1'b0);
      check("mtlo_busy_lo", o_lo, 32'h13579BDF);
      wait_done(n_cyc, n_busy);
      check("busy_op_lat", 32'(n_cyc), 32'd32);
      check("busy_op_hi", o_hi, 32'h0);
      check("busy_op_lo", o_lo, 32'd15);

      // Flush at cycle 10 of a multiply.
      issue(F_MULT, 32'h00001234, 32'h00005678, 1'b0);
      repeat (9) @(posedge i_clk);
      #1;
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      check("flush_busy", {31'd0, o_busy}, 32'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk);
         if (o_done) seen_done = 1'b1;
      end
      check("flush_no_done", {31'd0, seen_done}, 32'd0);
      check("flush_hi", o_hi, 32'h0);
      check("flush_lo", o_lo, 32'd15);

      // Flush landing in DONE suppresses the HI/LO write.
      issue(F_MULTU, 32'h00010000, 32'h00010000, 1'b0);
      seen_done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge i_clk);
         if (o_done) begin
            seen_done = 1'b1;
            break;
         end
      end
      check("done_reached", {31'd0, seen_done}, 32'd1);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      check("flush_done_hi", o_hi, 32'h0);
      check("flush_done_lo", o_lo, 32'd15);
      check("flush_done_busy", {31'd0, o_busy}, 32'd0);

      // Flush coincident with a hit in IDLE: nothing accepted.
      issue(F_MULTU, 32'd9, 32'd9, 1'b1);
      check("flush_hit_busy", {31'd0, o_busy}, 32'd0);
      issue(F_MTHI, 32'h55555555, 32'h0, 1'b1);
      check("flush_mthi_hi", o_hi, 32'h0);

      // Asynchronous reset in the middle of a divide.
      issue(F_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (5) @(negedge i_clk);
      check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      check("mid_rst_hi", o_hi, 32'h0);
      check("mid_rst_lo", o_lo, 32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      run_op("divu_again", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
